ram_scan_reader: RTL and testbench
==================================

Name: ram_scan_reader

Overview:
- Read-side controller for the 32x4 synchronous RAM on the board.
- Walks addresses 0..31 and issues reads, accounting for the RAM read latency.
- Captures each word and holds address/data stable for the hex display for a dwell period.
- Yields the RAM to the switch-driven writer on request via a req/grant handshake, then re-reads the current location so the display shows fresh data.

Parameters:
- ADDR_W, 5, RAM address width; scan wraps at 2^ADDR_W-1.
- DATA_W, 4, RAM word width.
- DWELL, 25000000, HOLD cycles per address in run mode; minimum 1.
- READ_LAT, 1, cycles from address registered to ram_q valid; legal values 1 or 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; continuous scan while high.
- step  in  1  single-cycle pulse; reads one address when run is low.
- wr_req  in  1  level; external writer requests the RAM.
- wr_grant  out  1  writer owns the RAM; the top-level mux selects writer address/data/wren.
- ram_address  out  ADDR_W  read address to RAM; always equals scan_addr.
- ram_wren  out  1  tied 0; the scanner never writes.
- ram_q  in  DATA_W  RAM read data.
- disp_addr  out  ADDR_W  address of the displayed word.
- disp_data  out  DATA_W  displayed word.
- disp_valid  out  1  disp_data is a completed read not invalidated by a write grant.
- wrap  out  1  one-cycle pulse when scan_addr goes from 31 to 0.

Behaviour:

Reset (synchronous):
- State goes to IDLE.
- scan_addr, disp_addr, disp_data, disp_valid, wr_grant and wrap all go to 0.
- Reset mid-read or mid-grant aborts immediately; wr_grant is 0 after that edge.

States: IDLE, ISSUE, WAIT, HOLD, YIELD.

IDLE:
- wr_req=1 -> YIELD. wr_req has priority over run and step.
- Else run=1 -> ISSUE.
- Else step=1 -> ISSUE, with step_mode set.
- Else stay in IDLE.

ISSUE:
- Lasts exactly 1 cycle, then -> WAIT.
- wr_req is not sampled.

WAIT:
- Lasts READ_LAT cycles.
- On the last WAIT edge: disp_data<=ram_q, disp_addr<=scan_addr, disp_valid<=1, then -> HOLD.
- Capture therefore occurs READ_LAT+1 edges after entering ISSUE.
- wr_req is not sampled; a read in flight always completes.

HOLD:
- Dwell counter starts at 0.
- If wr_req=1 -> YIELD. scan_addr is unchanged and the dwell count is discarded.
- Else, in run mode with run=1: count DWELL cycles. On expiry, scan_addr+1 (mod 32) -> ISSUE.
- Else (step_mode, or run dropped during HOLD): scan_addr+1 (mod 32) -> IDLE after 1 HOLD cycle.
- Whenever the increment is 31->0, wrap=1 for exactly that cycle.

YIELD:
- wr_grant=1 from the cycle after entry and throughout YIELD.
- disp_valid<=0 on entry; disp_addr and disp_data hold their values.
- When wr_req=0: wr_grant<=0 on that edge -> ISSUE (re-read of the same scan_addr).
- The re-read uses run mode if run=1; otherwise it returns to IDLE after its single HOLD cycle, without incrementing.

Other rules:
- step is ignored outside IDLE and is not queued.
- run and step asserted together: run wins.
- The address counter wraps silently except for the wrap pulse.
- No arithmetic beyond the mod-2^ADDR_W increment and the dwell counter. The dwell counter width is ceil(log2(DWELL+1)) and it saturates at no other value.
- ram_wren is constant 0.

Test Plan (bench uses DWELL=4, READ_LAT=1 and a behavioural 32x4 RAM with registered address, preloaded mem[a]=a mod 16):
- Reset held for 3 cycles, then released with no inputs -> every output is 0 and state stays IDLE for 20 cycles.
- Three step pulses 10 cycles apart -> disp_addr/disp_data = 0/0, then 1/1, then 2/2. Each is captured 2 edges after its step pulse, with disp_valid=1.
- run=1 for 300 cycles -> the address advances every 7 cycles (1 ISSUE + 1 WAIT + 4 HOLD + increment). disp_data follows a mod 16, and wrap pulses once on the 31->0 transition, for 1 cycle.
- In HOLD at address 5, wr_req=1 -> wr_grant=1 next cycle and disp_valid=0. The writer sets mem[5]=0xA, then wr_req=0 -> grant drops. Address 5 is re-read and shows disp_data=0xA, disp_valid=1, and scanning continues at 6.
- wr_req raised the cycle after ISSUE -> wr_grant stays 0 until the capture completes and HOLD is entered; it then asserts.
- reset asserted while in WAIT and while in YIELD -> all outputs are 0 after that edge; the next step reads address 0.

Source files
------------

// File: rtl/ram_scan_reader.sv
// ram_scan_reader: read-side scanner for the board's 32x4 synchronous RAM.
// Walks scan_addr through the RAM, waits out the read latency, latches each
// word for the hex display and dwells on it. Hands the RAM to the
// switch-driven writer on request, then re-reads the same location.
//
// Ports
//   clock, reset          system clock; synchronous active-high reset
//   run                   level, continuous scan while high
//   step                  one-cycle pulse, reads one address when run is low
//   wr_req / wr_grant     writer request / writer owns the RAM
//   ram_address, ram_wren read address (= scan_addr), write enable (always 0)
//   ram_q                 RAM read data
//   disp_addr/data/valid  word shown on the display
//   wrap                  one-cycle pulse when scan_addr wraps to 0
//
// state | meaning
// IDLE  | waiting for run, step or wr_req
// ISSUE | address presented to the RAM
// WAIT  | read latency, captures ram_q on the last cycle
// HOLD  | display dwell, then advance
// YIELD | writer owns the RAM
module ram_scan_reader #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 4,
    parameter int DWELL    = 25000000,
    parameter int READ_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              wr_req,
    output logic              wr_grant,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              wrap
);

    localparam int               CNT_W     = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] DWELL_C   = CNT_W'(DWELL);
    localparam logic             WAIT_LAST = 1'(READ_LAT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, YIELD} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   scan_addr_q, scan_addr_d;
    logic [ADDR_W-1:0]   disp_addr_q, disp_addr_d;
    logic [DATA_W-1:0]   disp_data_q, disp_data_d;
    logic                disp_valid_q, disp_valid_d;
    logic                wr_grant_q, wr_grant_d;
    logic                wrap_q, wrap_d;
    // single_q: leave HOLD after one cycle; no_inc_q: leave without advancing
    logic                single_q, single_d;
    logic                no_inc_q, no_inc_d;
    logic                wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    dwell_q, dwell_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            scan_addr_q  <= '0;
            disp_addr_q  <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            wr_grant_q   <= 1'b0;
            wrap_q       <= 1'b0;
            single_q     <= 1'b0;
            no_inc_q     <= 1'b0;
            wait_cnt_q   <= 1'b0;
            dwell_q      <= '0;
        end else begin
            state_q      <= state_d;
            scan_addr_q  <= scan_addr_d;
            disp_addr_q  <= disp_addr_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            wr_grant_q   <= wr_grant_d;
            wrap_q       <= wrap_d;
            single_q     <= single_d;
            no_inc_q     <= no_inc_d;
            wait_cnt_q   <= wait_cnt_d;
            dwell_q      <= dwell_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        scan_addr_d  = scan_addr_q;
        disp_addr_d  = disp_addr_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        wr_grant_d   = wr_grant_q;
        wrap_d       = 1'b0;
        single_d     = single_q;
        no_inc_d     = no_inc_q;
        wait_cnt_d   = wait_cnt_q;
        dwell_d      = dwell_q;

        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d      = YIELD;
                    wr_grant_d   = 1'b1;
                    disp_valid_d = 1'b0;
                end else if (run) begin
                    state_d  = ISSUE;
                    single_d = 1'b0;
                    no_inc_d = 1'b0;
                end else if (step) begin
                    state_d  = ISSUE;
                    single_d = 1'b1;
                    no_inc_d = 1'b0;
                end
            end
            ISSUE: begin
                state_d    = WAIT;
                wait_cnt_d = 1'b0;
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d      = HOLD;
                    disp_data_d  = ram_q;
                    disp_addr_d  = scan_addr_q;
                    disp_valid_d = 1'b1;
                    dwell_d      = '0;
                end else begin
                    wait_cnt_d = 1'b1;
                end
            end
            HOLD: begin
                if (wr_req) begin
                    state_d      = YIELD;
                    wr_grant_d   = 1'b1;
                    disp_valid_d = 1'b0;
                end else if (!single_q && run) begin
                    // The advance happens on the cycle after DWELL counted cycles.
                    if (dwell_q == DWELL_C) begin
                        state_d     = ISSUE;
                        scan_addr_d = scan_addr_q + ADDR_W'(1);
                        wrap_d      = &scan_addr_q;
                    end else begin
                        dwell_d = dwell_q + CNT_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                    if (!no_inc_q) begin
                        scan_addr_d = scan_addr_q + ADDR_W'(1);
                        wrap_d      = &scan_addr_q;
                    end
                end
            end
            YIELD: begin
                if (!wr_req) begin
                    // Re-read the same location; without run it parks afterwards.
                    state_d    = ISSUE;
                    wr_grant_d = 1'b0;
                    single_d   = !run;
                    no_inc_d   = !run;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_grant    = wr_grant_q;
    assign ram_address = scan_addr_q;
    assign ram_wren    = 1'b0;
    assign disp_addr   = disp_addr_q;
    assign disp_data   = disp_data_q;
    assign disp_valid  = disp_valid_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
module tb_ram_scan_reader;
    localparam int AW    = 5;
    localparam int DW    = 4;
    localparam int DWELL = 4;
    localparam int RL    = 1;

    logic          clock  = 1'b0;
    logic          reset  = 1'b1;
    logic          run    = 1'b0;
    logic          step   = 1'b0;
    logic          wr_req = 1'b0;
    logic          wr_grant, ram_wren, disp_valid, wrap;
    logic [AW-1:0] ram_address, disp_addr;
    logic [DW-1:0] ram_q, disp_data;

    logic [DW-1:0] mem [32];
    logic [AW-1:0] ram_addr_r = '0;

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int n_wrap = 0;
    bit rec_en = 1'b0;
    int chg_q[$];

    ram_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .DWELL(DWELL), .READ_LAT(RL)) dut (
        .clock(clock), .reset(reset), .run(run), .step(step), .wr_req(wr_req),
        .wr_grant(wr_grant), .ram_address(ram_address), .ram_wren(ram_wren),
        .ram_q(ram_q), .disp_addr(disp_addr), .disp_data(disp_data),
        .disp_valid(disp_valid), .wrap(wrap)
    );

    always #5 clock = ~clock;

    // Behavioural RAM: registered address, asynchronous array read after it.
    initial for (int a = 0; a < 32; a++) mem[a] = DW'(a % 16);
    always @(posedge clock) ram_addr_r <= ram_address;
    assign ram_q = mem[ram_addr_r];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [AW-1:0] m_scan  = '0;
    logic [AW-1:0] e_daddr = '0;
    logic [DW-1:0] e_ddata = '0;
    logic          e_valid = 1'b0;
    logic          e_grant = 1'b0;
    logic          e_wrap  = 1'b0;

    task automatic m_edge(output bit ok);
        @(posedge clock);
        e_wrap = 1'b0;
        ok = !reset;
        if (reset) begin
            m_scan = '0; e_daddr = '0; e_ddata = '0; e_valid = 1'b0; e_grant = 1'b0;
        end
    endtask

    task automatic m_advance();
        m_scan = AW'((int'(m_scan) + 1) % 32);
        e_wrap = (m_scan == '0);
    endtask

    initial begin : model
        int act;   // 0 idle, 1 read, 2 yield
        bit ok, single, noinc;
        int held;
        act = 0; single = 0; noinc = 0;
        forever begin
            if (act == 0) begin
                m_edge(ok);
                if (!ok) continue;
                if (wr_req) begin
                    e_grant = 1'b1; e_valid = 1'b0; act = 2;
                end else if (run) begin
                    single = 0; noinc = 0; act = 1;
                end else if (step) begin
                    single = 1; noinc = 0; act = 1;
                end
            end else if (act == 1) begin
                act = 0;
                ok = 1;
                for (int k = 0; k < RL + 1; k++) begin
                    m_edge(ok);
                    if (!ok) break;
                end
                if (!ok) continue;
                e_daddr = m_scan; e_ddata = mem[m_scan]; e_valid = 1'b1;
                held = 0;
                forever begin
                    m_edge(ok);
                    if (!ok) break;
                    if (wr_req) begin
                        e_grant = 1'b1; e_valid = 1'b0; act = 2; break;
                    end
                    if (!single && run) begin
                        if (held == DWELL) begin m_advance(); act = 1; break; end
                        held++;
                    end else begin
                        if (!noinc) m_advance();
                        break;
                    end
                end
            end else begin
                m_edge(ok);
                if (!ok) begin act = 0; continue; end
                if (!wr_req) begin
                    e_grant = 1'b0; single = !run; noinc = !run; act = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        logic [AW-1:0] last_addr;
        last_addr = '0;
        @(posedge clock);
        forever begin
            @(negedge clock);
            cyc++;
            check("ram_address", 32'(ram_address), 32'(m_scan));
            check("disp_addr",   32'(disp_addr),   32'(e_daddr));
            check("disp_data",   32'(disp_data),   32'(e_ddata));
            check("disp_valid",  32'(disp_valid),  32'(e_valid));
            check("wr_grant",    32'(wr_grant),    32'(e_grant));
            check("wrap",        32'(wrap),        32'(e_wrap));
            check("ram_wren",    32'(ram_wren),    32'd0);
            if (wrap === 1'b1) n_wrap++;
            if (rec_en && disp_valid && disp_addr != last_addr) chg_q.push_back(cyc);
            last_addr = disp_addr;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cycles(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_disp(logic [AW-1:0] a, int lim, string name);
        int i;
        for (i = 0; i < lim; i++) begin
            if (disp_valid === 1'b1 && disp_addr === a) break;
            @(negedge clock);
        end
        if (i == lim) check(name, 32'(disp_addr), 32'(a));
    endtask

    initial begin : stim
        int w0;
        logic [AW-1:0] a0;

        // reset for three edges, then idle
        repeat (3) @(negedge clock);
        reset = 1'b0;
        cycles(20);
        check("idle_valid", 32'(disp_valid), 32'd0);
        check("idle_addr",  32'(ram_address), 32'd0);

        // three step pulses, capture two edges after the sampling edge
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            @(negedge clock);
            step = 1'b0;
            @(negedge clock);
            check("step_pre_valid", 32'(disp_valid), (k == 0) ? 32'd0 : 32'd1);
            @(negedge clock);
            check("step_valid", 32'(disp_valid), 32'd1);
            check("step_addr",  32'(disp_addr),  32'(k));
            check("step_data",  32'(disp_data),  32'(k));
            cycles(7);
        end
        check("after_steps_addr", 32'(ram_address), 32'd3);

        // continuous scan
        w0 = n_wrap;
        rec_en = 1'b1;
        run = 1'b1;
        cycles(300);
        run = 1'b0;
        rec_en = 1'b0;
        check("run_wrap_count", 32'(n_wrap - w0), 32'd1);
        check("run_cadence_samples", 32'(chg_q.size() >= 6), 32'd1);
        if (chg_q.size() >= 6) begin
            check("run_period_a", 32'(chg_q[1] - chg_q[0]), 32'd7);
            check("run_period_b", 32'(chg_q[5] - chg_q[4]), 32'd7);
        end
        cycles(15);

        // writer takes the RAM while address 5 is held
        run = 1'b1;
        wait_disp(5'd5, 400, "reach_addr5_timeout");
        wr_req = 1'b1;
        @(negedge clock);
        check("yield_grant", 32'(wr_grant),   32'd1);
        check("yield_valid", 32'(disp_valid), 32'd0);
        check("yield_addr",  32'(disp_addr),  32'd5);
        mem[5] = 4'hA;
        cycles(2);
        wr_req = 1'b0;
        @(negedge clock);
        check("release_grant", 32'(wr_grant), 32'd0);
        wait_disp(5'd5, 20, "reread_timeout");
        check("reread_data", 32'(disp_data), 32'hA);
        begin
            int i;
            for (i = 0; i < 30; i++) begin
                if (disp_addr !== 5'd5) break;
                @(negedge clock);
            end
            check("continue_addr", 32'(disp_addr), 32'd6);
        end
        run = 1'b0;
        cycles(15);

        // wr_req raised while the read is in flight
        a0 = ram_address;
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        @(negedge clock);
        wr_req = 1'b1;
        check("inflight_grant0", 32'(wr_grant), 32'd0);
        @(negedge clock);
        check("inflight_grant1", 32'(wr_grant),   32'd0);
        check("inflight_valid",  32'(disp_valid), 32'd1);
        check("inflight_addr",   32'(disp_addr),  32'(a0));
        @(negedge clock);
        check("inflight_grant2", 32'(wr_grant),   32'd1);
        check("inflight_valid2", 32'(disp_valid), 32'd0);
        cycles(2);
        wr_req = 1'b0;
        cycles(10);
        check("reread_noinc_addr",  32'(ram_address), 32'(a0));
        check("reread_noinc_valid", 32'(disp_valid),  32'd1);

        // reset during WAIT
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_wait_addr",  32'(ram_address), 32'd0);
        check("rst_wait_valid", 32'(disp_valid),  32'd0);
        check("rst_wait_daddr", 32'(disp_addr),   32'd0);
        check("rst_wait_ddata", 32'(disp_data),   32'd0);
        check("rst_wait_grant", 32'(wr_grant),    32'd0);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        cycles(6);
        check("post_rst_scan", 32'(ram_address), 32'd1);

        // reset during YIELD
        wr_req = 1'b1;
        cycles(3);
        check("pre_rst_grant", 32'(wr_grant), 32'd1);
        reset = 1'b1;
        wr_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check("rst_yield_grant", 32'(wr_grant),    32'd0);
        check("rst_yield_addr",  32'(ram_address), 32'd0);
        check("rst_yield_valid", 32'(disp_valid),  32'd0);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_step_valid", 32'(disp_valid), 32'd1);
        check("rst_step_addr",  32'(disp_addr),  32'd0);
        check("rst_step_data",  32'(disp_data),  32'd0);
        cycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
